// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : 5-stage MIPS hazard control: forwarding selects, load-use and
//             branch stalls, E flush, and a start/ready hold for the divider.
//  Option   : define HAZARD_PERF_EN to add saturating stall/flush counters.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_unit #(
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic            branchD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            divE,
  input  logic            div_readyE,
  output logic            div_startE,
  output logic            forwardaD,
  output logic            forwardbD,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
`ifdef HAZARD_PERF_EN
  output logic [CNTW-1:0] stall_cycles,
  output logic [CNTW-1:0] flush_count,
`endif
  output logic            flushE
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic w_lwstall;
  logic w_branchstall;
  logic w_divstall;
  logic w_src_stall;

  // M has priority over W because it holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [REGW-1:0] src,
    input logic [REGW-1:0] wr_m,
    input logic            we_m,
    input logic [REGW-1:0] wr_w,
    input logic            we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0 && src == wr_m && we_m) begin
      sel = 2'b10;
    end else if (src != '0 && src == wr_w && we_w) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  function automatic logic hits(
    input logic [REGW-1:0] dst,
    input logic [REGW-1:0] a,
    input logic [REGW-1:0] b
  );
    return (dst != '0) && (dst == a || dst == b);
  endfunction

  always_comb begin
    forwardaE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    forwardbE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
    forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
  end

  always_comb begin
    w_lwstall     = memtoregE && regwriteE && hits(writeregE, rsD, rtD);
    w_branchstall = branchD &&
                    ((regwriteE && hits(writeregE, rsD, rtD)) ||
                     (memtoregM && hits(writeregM, rsD, rtD)));
    w_divstall    = (state_q == ST_IDLE) ? divE : !div_readyE;
    w_src_stall   = w_lwstall || w_branchstall;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (divE)       state_d = ST_BUSY;
      ST_BUSY: if (div_readyE) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset masks every pipeline-control output; forwarding stays live.
  always_comb begin
    div_startE = !rst && (state_q == ST_IDLE) && divE;
    stallF     = !rst && (w_src_stall || w_divstall);
    stallD     = !rst && (w_src_stall || w_divstall);
    stallE     = !rst && w_divstall;
    flushE     = !rst && w_src_stall && !w_divstall;
  end

`ifdef HAZARD_PERF_EN
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stallD && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNTW'(1);
    if (flushE && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  logic unused_cntw;
  assign unused_cntw = |CNTW;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit
//  Purpose  : Directed plus randomized self-checking bench for hazard_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       divE, div_readyE;
  logic       div_startE, forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;
  logic       stallF, stallD, stallE, flushE;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
  int unsigned exp_stall_cnt, exp_flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit div_outstanding;

  always #5 clk = ~clk;

  hazard_unit #(.REGW(5), .CNTW(32)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .divE(divE), .div_readyE(div_readyE), .div_startE(div_startE),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .flushE(flushE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference rules, straight from the hazard definitions.
  function automatic logic [1:0] m_fwdE(input logic [4:0] r);
    if (r != 0 && r == writeregM && regwriteM) return 2'b10;
    if (r != 0 && r == writeregW && regwriteW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_dep(input logic [4:0] dst);
    return dst != 0 && (dst == rsD || dst == rtD);
  endfunction

  function automatic bit m_lw();
    return memtoregE && regwriteE && m_dep(writeregE);
  endfunction

  function automatic bit m_br();
    return branchD && ((regwriteE && m_dep(writeregE)) || (memtoregM && m_dep(writeregM)));
  endfunction

  // The divide holds the pipe until its result is ready.
  function automatic bit m_div();
    return div_outstanding ? !div_readyE : divE;
  endfunction

  function automatic bit m_stallD();
    return !rst && (m_lw() || m_br() || m_div());
  endfunction

  function automatic bit m_flush();
    return !rst && (m_lw() || m_br()) && !m_div();
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".fwdaE"}, 32'(forwardaE), 32'(m_fwdE(rsE)));
    check({tag, ".fwdbE"}, 32'(forwardbE), 32'(m_fwdE(rtE)));
    check({tag, ".fwdaD"}, 32'(forwardaD), 32'(rsD != 0 && rsD == writeregM && regwriteM));
    check({tag, ".fwdbD"}, 32'(forwardbD), 32'(rtD != 0 && rtD == writeregM && regwriteM));
    check({tag, ".stallF"}, 32'(stallF), 32'(m_stallD()));
    check({tag, ".stallD"}, 32'(stallD), 32'(m_stallD()));
    check({tag, ".stallE"}, 32'(stallE), 32'(!rst && m_div()));
    check({tag, ".flushE"}, 32'(flushE), 32'(m_flush()));
    check({tag, ".start"}, 32'(div_startE), 32'(!rst && !div_outstanding && divE));
`ifdef HAZARD_PERF_EN
    check({tag, ".scnt"}, stall_cycles, exp_stall_cnt);
    check({tag, ".fcnt"}, flush_count, exp_flush_cnt);
`endif
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic step();
    @(posedge clk);
`ifdef HAZARD_PERF_EN
    if (rst) begin
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else begin
      if (m_stallD() && exp_stall_cnt != 32'hFFFF_FFFF) exp_stall_cnt++;
      if (m_flush() && exp_flush_cnt != 32'hFFFF_FFFF) exp_flush_cnt++;
    end
`endif
    if (rst) div_outstanding = 1'b0;
    else if (!div_outstanding && divE) div_outstanding = 1'b1;
    else if (div_outstanding && div_readyE) div_outstanding = 1'b0;
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    branchD = 0; regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; divE = 0; div_readyE = 0;
  endtask

  initial begin
    div_outstanding = 1'b0;
`ifdef HAZARD_PERF_EN
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
`endif
    clear_inputs();
    rst = 1; divE = 1;
    #1;
    step(); step();
    check("rst.stallE", 32'(stallE), 32'd0);
    check("rst.start", 32'(div_startE), 32'd0);
    check_all("rst");
    clear_inputs();
    #1;

    // Forward priority
    rsE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1; #1;
    check("fwd.M", 32'(forwardaE), 32'd2); check_all("fwdM");
    regwriteM = 0; #1;
    check("fwd.W", 32'(forwardaE), 32'd1); check_all("fwdW");
    rsE = 0; regwriteM = 1; #1;
    check("fwd.r0", 32'(forwardaE), 32'd0); check_all("fwd0");
    clear_inputs(); #1;

    // Load-use
    memtoregE = 1; regwriteE = 1; writeregE = 8; rtD = 8; #1;
    check("lw.stallD", 32'(stallD), 32'd1);
    check("lw.flushE", 32'(flushE), 32'd1);
    check("lw.stallE", 32'(stallE), 32'd0);
    check_all("lw");
    writeregE = 9; #1;
    check("lw.none", 32'({stallF, stallD, stallE, flushE}), 32'd0);
    clear_inputs(); #1;

    // Branch hazard
    branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3; #1;
    check("br.E", 32'({stallD, flushE}), 32'd3); check_all("brE");
    step();
    regwriteE = 0; writeregE = 0; writeregM = 3; memtoregM = 1; regwriteM = 1; #1;
    check("br.Mload", 32'(stallD), 32'd1); check_all("brML");
    memtoregM = 0; #1;
    check("br.Mfwd", 32'({stallD, forwardaD}), 32'd1); check_all("brMF");
    clear_inputs(); #1;

    // Divide: start at cycle 0, ready at cycle 4, back-to-back at cycle 5
    for (int c = 0; c <= 5; c++) begin
      divE = 1; div_readyE = (c == 4); #1;
      check($sformatf("div.start%0d", c), 32'(div_startE), 32'(c == 0 || c == 5));
      check($sformatf("div.stallE%0d", c), 32'(stallE), 32'(c != 4));
      check_all("div");
      step();
    end
    divE = 0; div_readyE = 1; #1;
    check_all("div.end");
    step();

    // Reset mid-divide, then a late ready
    clear_inputs(); divE = 1; #1; step();
    divE = 0; step(); step();
    rst = 1; lw_setup(); #1;
    check("rstbusy.stall", 32'({stallF, stallD, stallE, flushE, div_startE}), 32'd0);
    check_all("rstbusy");
    step();
    clear_inputs(); div_readyE = 1; #1;
    check("late.stallE", 32'(stallE), 32'd0);
    check_all("late");
    step();
    div_readyE = 0; #1;
    check_all("late2");
    step();

`ifdef HAZARD_PERF_EN
    clear_inputs(); rst = 1; #1; step();
    rst = 0; lw_setup();
    for (int c = 0; c < 3; c++) step();
    clear_inputs(); divE = 1;
    for (int c = 0; c < 4; c++) step();
    div_readyE = 1; step();
    clear_inputs(); #1;
    check("perf.stall", stall_cycles, 32'd7);
    check("perf.flush", flush_count, 32'd3);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      rsD        = 5'($urandom_range(0, 3));
      rtD        = 5'($urandom_range(0, 3));
      rsE        = 5'($urandom_range(0, 3));
      rtE        = 5'($urandom_range(0, 3));
      writeregE  = 5'($urandom_range(0, 3));
      writeregM  = 5'($urandom_range(0, 3));
      writeregW  = 5'($urandom_range(0, 3));
      branchD    = 1'($urandom);
      regwriteE  = 1'($urandom);
      regwriteM  = 1'($urandom);
      regwriteW  = 1'($urandom);
      memtoregE  = 1'($urandom);
      memtoregM  = 1'($urandom);
      divE       = ($urandom_range(0, 2) == 0);
      div_readyE = ($urandom_range(0, 3) == 0);
      #1;
      check_all("rnd");
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  task automatic lw_setup();
    memtoregE = 1; regwriteE = 1; writeregE = 8; rtD = 8;
  endtask

endmodule
`default_nettype wire
